// File: rtl/ds_capture_pkg.sv
// Shared types and helpers for the decimated-sample capture buffer.
package ds_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DROP_W = 16;

    // A zero or oversized request means "fill the whole RAM".
    function automatic int unsigned eff_len(input int unsigned cap_len, input int unsigned depth);
        return (cap_len == 0 || cap_len > depth) ? depth : cap_len;
    endfunction

endpackage

// File: rtl/ds_capture_ram.sv
// Simple dual-port sample RAM: one write port, registered read port (read-before-write).
module ds_capture_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ds_capture_buffer.sv
// Triggered snapshot of decimated samples into block RAM for CSR readout.
// Define DS_CAPTURE_PEAK_EN to track the peak |sample| of the stored record.
module ds_capture_buffer
    import ds_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         trig_mode,
    input  logic signed [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH:0]          cap_len,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [1:0]                   state,
    output logic                         done,
    output logic [ADDR_WIDTH:0]          wr_count,
    output logic [DROP_W-1:0]            dropped,
    output logic [DATA_WIDTH-1:0]        peak_abs
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH:0]          wr_count_q, wr_count_d;
    logic [ADDR_WIDTH:0]          len_q, len_d;
    logic [DROP_W-1:0]            dropped_q, dropped_d;
    logic signed [DATA_WIDTH-1:0] level_q, level_d;
    logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                         mode_q, mode_d;
    logic                         prev_vld_q, prev_vld_d;
    logic                         we;
    logic                         trig;
    logic                         arm_go;
    logic [ADDR_WIDTH-1:0]        waddr;

    assign arm_go = arm & ~abort;
    assign waddr  = (state_q == ST_ARMED) ? '0 : wr_count_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        len_d      = len_q;
        dropped_d  = dropped_q;
        level_d    = level_q;
        prev_d     = prev_q;
        mode_d     = mode_q;
        prev_vld_d = prev_vld_q;
        we         = 1'b0;
        trig       = 1'b0;

        // Control pulses pre-empt the FSM and swallow any coincident sample.
        if (abort) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d    = ST_ARMED;
            wr_count_d = '0;
            dropped_d  = '0;
            prev_vld_d = 1'b0;
            len_d      = (ADDR_WIDTH+1)'(eff_len(32'(cap_len), DEPTH));
            level_d    = trig_level;
            mode_d     = trig_mode;
        end else begin
            unique case (state_q)
                ST_ARMED: begin
                    if (sample_valid) begin
                        if (mode_q) begin
                            trig       = prev_vld_q && (prev_q < level_q) && (sample_in >= level_q);
                            prev_d     = sample_in;
                            prev_vld_d = 1'b1;
                        end else begin
                            trig = 1'b1;
                        end
                        if (trig) begin
                            we         = 1'b1;
                            wr_count_d = (ADDR_WIDTH+1)'(1);
                            state_d    = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (wr_count_q == len_q) begin
                        state_d = ST_DONE;
                    end else if (sample_valid) begin
                        we         = 1'b1;
                        wr_count_d = wr_count_q + (ADDR_WIDTH+1)'(1);
                    end
                end
                ST_DONE: begin
                    if (sample_valid && dropped_q != '1) begin
                        dropped_d = dropped_q + DROP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            dropped_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            dropped_q  <= dropped_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q   <= len_d;
        level_q <= level_d;
        mode_q  <= mode_d;
        prev_q  <= prev_d;
    end

    ds_capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we_i   (we),
        .waddr_i(waddr),
        .wdata_i(sample_in),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    assign state    = state_q;
    assign done     = (state_q == ST_DONE);
    assign wr_count = wr_count_q;
    assign dropped  = dropped_q;

`ifdef DS_CAPTURE_PEAK_EN
    logic                  pk_pend_q;
    logic [DATA_WIDTH-1:0] pk_samp_q;
    logic [DATA_WIDTH-1:0] peak_q;

    // Most-negative input has no positive twin; clamp it to the largest positive value.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic signed [DATA_WIDTH-1:0] s);
        if (s == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return s[DATA_WIDTH-1] ? DATA_WIDTH'(-s) : DATA_WIDTH'(s);
    endfunction

    always_ff @(posedge clk) begin
        pk_samp_q <= abs_sat(sample_in);
    end

    always_ff @(posedge clk) begin
        if (reset || arm_go) begin
            pk_pend_q <= 1'b0;
            peak_q    <= '0;
        end else begin
            pk_pend_q <= we;
            if (pk_pend_q && pk_samp_q > peak_q) begin
                peak_q <= pk_samp_q;
            end
        end
    end

    assign peak_abs = peak_q;
`else
    assign peak_abs = '0;
`endif

endmodule
